// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and defaults for the RAM access controller
package mem_ctrl_pkg;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      CAPT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef enum logic {
      PORT_IF = 1'b0,
      PORT_D  = 1'b1
   } port_id_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - core-side fetch and load/store request/response bundle
interface mem_access_ctrl_if
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);

   logic              if_req_valid;
   logic              if_req_ready;
   logic [ADDR_W-1:0] if_req_addr;
   logic              if_rsp_valid;
   logic              if_rsp_ready;
   logic [DATA_W-1:0] if_rsp_data;

   logic              d_req_valid;
   logic              d_req_ready;
   logic              d_req_we;
   logic [ADDR_W-1:0] d_req_addr;
   logic [DATA_W-1:0] d_req_wdata;
   logic              d_rsp_valid;
   logic              d_rsp_ready;
   logic [DATA_W-1:0] d_rsp_rdata;

   modport master (
      output if_req_valid, if_req_addr, if_rsp_ready,
      output d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_rsp_ready,
      input  if_req_ready, if_rsp_valid, if_rsp_data,
      input  d_req_ready, d_rsp_valid, d_rsp_rdata
   );

   modport slave (
      input  if_req_valid, if_req_addr, if_rsp_ready,
      input  d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_rsp_ready,
      output if_req_ready, if_rsp_valid, if_rsp_data,
      output d_req_ready, d_rsp_valid, d_rsp_rdata
   );

endinterface

// File: rtl/mem_access_ctrl_arbiter.sv
// rtl/mem_access_ctrl_arbiter.sv - data-first arbiter with a fetch starvation limit
module mem_arbiter
   import mem_ctrl_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     i_if_valid,
   input  logic     i_d_valid,
   input  logic     i_accept,
   input  port_id_t i_grant_id,
   output logic     o_grant_valid,
   output port_id_t o_grant
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_starved;

   assign w_starved     = (r_cnt == CNT_W'(STARVE_LIMIT));
   assign o_grant_valid = i_if_valid | i_d_valid;

   always_comb begin
      o_grant = PORT_IF;
      if (i_d_valid && !(i_if_valid && w_starved))
         o_grant = PORT_D;
   end

   // Counts data grants that bypassed a waiting fetch; saturates at the limit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_accept) begin
         if (i_grant_id == PORT_IF || !i_if_valid)
            r_cnt <= '0;
         else if (!w_starved)
            r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - arbitrates fetch and load/store onto one synchronous RAM port
module mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   mem_access_ctrl_if.slave  bus,
   output logic              ram_wr_en,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_data_in,
   input  logic [DATA_W-1:0] ram_data_out,
   output logic              busy
);

   state_t            r_state, w_next;
   port_id_t          r_port, w_grant;
   logic              r_we;
   logic              r_ram_wr_en;
   logic [ADDR_W-1:0] r_ram_addr;
   logic [DATA_W-1:0] r_ram_wdata;
   logic [DATA_W-1:0] r_if_rsp_data, r_d_rsp_data;
   logic              w_grant_valid, w_accept, w_rsp_hs;

   mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
      .clk           (clk),
      .rst           (rst),
      .i_if_valid    (bus.if_req_valid),
      .i_d_valid     (bus.d_req_valid),
      .i_accept      (w_accept),
      .i_grant_id    (w_grant),
      .o_grant_valid (w_grant_valid),
      .o_grant       (w_grant)
   );

   assign w_accept = (r_state == IDLE) && w_grant_valid;
   assign w_rsp_hs = (r_state == RESP) &&
                     ((r_port == PORT_IF) ? bus.if_rsp_ready : bus.d_rsp_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = ISSUE;
         ISSUE:   w_next = CAPT;
         CAPT:    w_next = RESP;
         RESP:    if (w_rsp_hs) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      bus.if_req_ready = 1'b0;
      bus.d_req_ready  = 1'b0;
      bus.if_rsp_valid = 1'b0;
      bus.d_rsp_valid  = 1'b0;
      busy             = (r_state != IDLE);
      if (w_accept) begin
         if (w_grant == PORT_IF) bus.if_req_ready = 1'b1;
         else                    bus.d_req_ready  = 1'b1;
      end
      if (r_state == RESP) begin
         if (r_port == PORT_IF) bus.if_rsp_valid = 1'b1;
         else                   bus.d_rsp_valid  = 1'b1;
      end
   end

   // Request fields are captured once at the handshake; the RAM read lands in CAPT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_port        <= PORT_IF;
         r_we          <= 1'b0;
         r_ram_wr_en   <= 1'b0;
         r_ram_addr    <= '0;
         r_ram_wdata   <= '0;
         r_if_rsp_data <= '0;
         r_d_rsp_data  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_port <= w_grant;
                  if (w_grant == PORT_D) begin
                     r_we        <= bus.d_req_we;
                     r_ram_wr_en <= bus.d_req_we;
                     r_ram_addr  <= bus.d_req_addr;
                     r_ram_wdata <= bus.d_req_wdata;
                  end else begin
                     r_we        <= 1'b0;
                     r_ram_wr_en <= 1'b0;
                     r_ram_addr  <= bus.if_req_addr;
                     r_ram_wdata <= '0;
                  end
               end
            end
            ISSUE: r_ram_wr_en <= 1'b0;
            CAPT: begin
               if (r_port == PORT_IF) r_if_rsp_data <= ram_data_out;
               else                   r_d_rsp_data  <= r_we ? '0 : ram_data_out;
            end
            default: ;
         endcase
      end
   end

   assign ram_wr_en       = r_ram_wr_en;
   assign ram_address     = r_ram_addr;
   assign ram_data_in     = r_ram_wdata;
   assign bus.if_rsp_data = r_if_rsp_data;
   assign bus.d_rsp_rdata = r_d_rsp_data;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;

   localparam int LIMIT = 4;

   typedef struct { bit we; logic [7:0] addr; logic [31:0] wdata; } req_t;
   typedef struct { bit port; logic [31:0] data; int cyc; } rsp_t;
   typedef struct { int cyc; logic [7:0] addr; logic [31:0] data; } wr_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ram_wr_en, busy;
   logic [7:0]  ram_address;
   logic [31:0] ram_data_in, ram_data_out;
   logic [31:0] ram_mem [256];
   logic [31:0] ref_mem [256];

   mem_access_ctrl_if bus ();

   mem_access_ctrl #(.ADDR_W(8), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .ram_wr_en    (ram_wr_en),
      .ram_address  (ram_address),
      .ram_data_in  (ram_data_in),
      .ram_data_out (ram_data_out),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_wr_en === 1'b1) ram_mem[ram_address] <= ram_data_in;
      ram_data_out <= ram_mem[ram_address];
   end

   req_t q_if[$], q_d[$];
   rsp_t sb[$];
   wr_t  wq[$];
   bit   glog[$];
   req_t cur_if, cur_d;
   int   n_cmp = 0, n_fail = 0, cyc = 0;
   int   starve = 0, last_acc = -100, n_acc = 0;
   int   gap_pct = 0, bp_hold = 0;
   bit   rsp_rand = 1'b0, in_reset = 1'b1;
   bit   acc_if, acc_d, holding, prev_hs, prev_wr, held_port;
   logic [31:0] held_data;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic req_t mk_req(input bit we, input logic [7:0] addr, input logic [31:0] wdata);
      req_t r;
      r.we = we; r.addr = addr; r.wdata = wdata;
      return r;
   endfunction

   function automatic logic [7:0] rand_addr();
      case ($urandom_range(3))
         0:       return 8'hFF;
         1:       return 8'($urandom_range(15));
         default: return 8'($urandom_range(255));
      endcase
   endfunction

   task automatic preset(input logic [7:0] a, input logic [31:0] v);
      ram_mem[a] = v;
      ref_mem[a] = v;
   endtask

   // Driver: presents queued requests, predicts arbitration and expected responses.
   always @(negedge clk) begin
      bit ifv, dv, ig, dg, exp_g, act_g;
      logic [31:0] d;
      if (!in_reset) begin
         if (acc_if) begin bus.if_req_valid = 1'b0; acc_if = 1'b0; end
         if (acc_d)  begin bus.d_req_valid  = 1'b0; acc_d  = 1'b0; end
         if (!bus.if_req_valid && q_if.size() != 0 && $urandom_range(99) >= gap_pct) begin
            cur_if = q_if.pop_front();
            bus.if_req_valid = 1'b1;
            bus.if_req_addr  = cur_if.addr;
         end
         if (!bus.d_req_valid && q_d.size() != 0 && $urandom_range(99) >= gap_pct) begin
            cur_d = q_d.pop_front();
            bus.d_req_valid = 1'b1;
            bus.d_req_we    = cur_d.we;
            bus.d_req_addr  = cur_d.addr;
            bus.d_req_wdata = cur_d.wdata;
         end
         #1;
         ifv = bus.if_req_valid; dv = bus.d_req_valid;
         ig  = bus.if_req_ready; dg = bus.d_req_ready;
         if (ifv || dv) chk("req_ready_only_when_idle", ig | dg, !busy);
         if (ig || dg) begin
            chk("single_grant", ig & dg, 0);
            act_g = dg;
            chk("ready_has_valid", act_g ? dv : ifv, 1);
            exp_g = dv && !(ifv && starve == LIMIT);
            chk("arb_grant", act_g, exp_g);
            chk("accept_spacing", (cyc - last_acc) >= 4, 1);
            if (exp_g) starve = ifv ? ((starve < LIMIT) ? starve + 1 : starve) : 0;
            else       starve = 0;
            if (!act_g) begin
               d = ref_mem[cur_if.addr];
               acc_if = 1'b1;
            end else if (cur_d.we) begin
               ref_mem[cur_d.addr] = cur_d.wdata;
               wq.push_back('{cyc: cyc + 1, addr: cur_d.addr, data: cur_d.wdata});
               d = 32'h0;
               acc_d = 1'b1;
            end else begin
               d = ref_mem[cur_d.addr];
               acc_d = 1'b1;
            end
            sb.push_back('{port: act_g, data: d, cyc: cyc + 3});
            glog.push_back(act_g);
            last_acc = cyc;
            n_acc++;
         end
      end
   end

   // Monitor: checks responses against the scoreboard and the RAM write strobe.
   always @(negedge clk) begin
      bit ifv, dv, port, rdy;
      logic [31:0] d;
      rsp_t e;
      wr_t  w;
      if (!in_reset) begin
         #2;
         ifv = bus.if_rsp_valid; dv = bus.d_rsp_valid;
         if (prev_hs) begin
            chk("idle_after_rsp_handshake", busy, 0);
            prev_hs = 1'b0;
         end
         if (ifv || dv) begin
            port = dv;
            d    = dv ? bus.d_rsp_rdata : bus.if_rsp_data;
            chk("single_rsp_valid", ifv & dv, 0);
            chk("busy_during_rsp", busy, 1);
            if (!holding) begin
               chk("rsp_expected", sb.size() != 0, 1);
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  chk("rsp_port", port, e.port);
                  chk("rsp_data", d, e.data);
                  chk("rsp_latency", cyc, e.cyc);
               end
               held_port = port;
               held_data = d;
            end else begin
               chk("rsp_hold_port", port, held_port);
               chk("rsp_hold_data", d, held_data);
            end
            if (bp_hold > 0) begin rdy = 1'b0; bp_hold--; end
            else rdy = rsp_rand ? ($urandom_range(3) != 0) : 1'b1;
            if (port) begin bus.d_rsp_ready  = rdy; bus.if_rsp_ready = 1'($urandom_range(1)); end
            else      begin bus.if_rsp_ready = rdy; bus.d_rsp_ready  = 1'($urandom_range(1)); end
            holding = !rdy;
            prev_hs = rdy;
         end else begin
            holding = 1'b0;
            bus.if_rsp_ready = 1'($urandom_range(1));
            bus.d_rsp_ready  = 1'($urandom_range(1));
         end
         if (ram_wr_en === 1'b1 || (wq.size() != 0 && wq[0].cyc == cyc)) begin
            chk("wr_en_pulse", ram_wr_en, 1);
            chk("wr_en_not_back_to_back", prev_wr, 0);
            chk("write_expected", wq.size() != 0, 1);
            if (wq.size() != 0) begin
               w = wq.pop_front();
               chk("wr_cycle", cyc, w.cyc);
               chk("wr_addr", ram_address, w.addr);
               chk("wr_data", ram_data_in, w.data);
            end
         end
         prev_wr = ram_wr_en;
      end
   end

   task automatic wait_idle(input int budget);
      int n = 0;
      @(negedge clk); #3;
      while ((q_if.size() != 0 || q_d.size() != 0 || sb.size() != 0 ||
              bus.if_req_valid || bus.d_req_valid || busy) && n < budget) begin
         @(negedge clk); #3;
         n++;
      end
      chk("drain_in_budget", n < budget, 1);
      chk("scoreboard_drained", sb.size(), 0);
      chk("writes_drained", wq.size(), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ram_wr_en"},    ram_wr_en, 0);
      chk({tag, "_ram_address"},  ram_address, 0);
      chk({tag, "_ram_data_in"},  ram_data_in, 0);
      chk({tag, "_busy"},         busy, 0);
      chk({tag, "_if_req_ready"}, bus.if_req_ready, 0);
      chk({tag, "_d_req_ready"},  bus.d_req_ready, 0);
      chk({tag, "_if_rsp_valid"}, bus.if_rsp_valid, 0);
      chk({tag, "_d_rsp_valid"},  bus.d_rsp_valid, 0);
      chk({tag, "_if_rsp_data"},  bus.if_rsp_data, 0);
      chk({tag, "_d_rsp_rdata"},  bus.d_rsp_rdata, 0);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      bit gseq [10];
      int start, n;
      gseq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      bus.if_req_valid = 1'b0; bus.if_req_addr = '0; bus.if_rsp_ready = 1'b0;
      bus.d_req_valid = 1'b0; bus.d_req_we = 1'b0; bus.d_req_addr = '0;
      bus.d_req_wdata = '0; bus.d_rsp_ready = 1'b0;
      for (int i = 0; i < 256; i++) begin
         ram_mem[i] = $urandom;
         ref_mem[i] = ram_mem[i];
      end

      repeat (3) @(posedge clk);
      #2;
      check_reset_outputs("por");
      @(negedge clk); rst = 1'b0; #4; in_reset = 1'b0;

      preset(8'h00, 32'h08000020);
      bp_hold = 5;
      q_if.push_back(mk_req(1'b0, 8'h00, 32'h0));
      wait_idle(100);
      chk("backpressure_applied", bp_hold, 0);

      q_d.push_back(mk_req(1'b1, 8'hBB, 32'hDEADBEEF));
      q_d.push_back(mk_req(1'b0, 8'hBB, 32'h0));
      wait_idle(100);
      chk("ram_bb_written", ram_mem[8'hBB], 32'hDEADBEEF);

      preset(8'hFF, 32'h766E2C96);
      q_d.push_back(mk_req(1'b0, 8'hFF, 32'h0));
      q_if.push_back(mk_req(1'b0, 8'h00, 32'h0));
      wait_idle(100);

      glog.delete();
      for (int i = 0; i < 12; i++) q_d.push_back(mk_req(1'b0, rand_addr(), 32'h0));
      for (int i = 0; i < 4; i++)  q_if.push_back(mk_req(1'b0, rand_addr(), 32'h0));
      wait_idle(400);
      for (int i = 0; i < 10; i++)
         chk($sformatf("starve_seq%0d", i), (i < glog.size()) ? 64'(glog[i]) : 64'd2, gseq[i]);

      rsp_rand = 1'b1;
      gap_pct  = 30;
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(1) == 1) q_if.push_back(mk_req(1'b0, rand_addr(), 32'h0));
         else q_d.push_back(mk_req(1'($urandom_range(1)), rand_addr(), $urandom));
      end
      wait_idle(5000);
      rsp_rand = 1'b0;
      gap_pct  = 0;

      preset(8'h10, 32'h11111111);
      start = n_acc;
      n = 0;
      q_d.push_back(mk_req(1'b1, 8'h10, 32'hCAFEF00D));
      while (n_acc == start && n < 50) begin @(posedge clk); n++; end
      chk("store_accepted", n_acc != start, 1);
      #1;
      chk("issue_wr_en", ram_wr_en, 1);
      #2;
      rst = 1'b1; in_reset = 1'b1;
      bus.d_req_valid = 1'b0; bus.if_req_valid = 1'b0;
      #1;
      check_reset_outputs("issue_rst");
      @(posedge clk); #1;
      chk("ram_10_kept", ram_mem[8'h10], 32'h11111111);
      sb.delete(); wq.delete();
      acc_if = 1'b0; acc_d = 1'b0; holding = 1'b0; prev_hs = 1'b0; prev_wr = 1'b0;
      starve = 0; last_acc = -100; bp_hold = 0;
      ref_mem[8'h10] = 32'h11111111;
      @(negedge clk); rst = 1'b0; #4; in_reset = 1'b0;
      chk("busy_after_reset", busy, 0);

      q_d.push_back(mk_req(1'b0, 8'h10, 32'h0));
      q_if.push_back(mk_req(1'b0, 8'h10, 32'h0));
      wait_idle(100);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
